// File: rtl/rr_burst_arbiter_pkg.sv
// rr_burst_arbiter_pkg: width helper and FSM state encoding shared by the arbiter files
package rr_burst_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// rr_pick: combinational wrap-around scan returning the first set req bit at or after start
module rr_pick #(
  parameter int N = 5,
  parameter int PTRW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] start,
  output logic [PTRW-1:0] win,
  output logic            found
);
  logic [PTRW:0] idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, start} + (PTRW + 1)'(i);
      idx = (idx >= (PTRW + 1)'(N)) ? idx - (PTRW + 1)'(N) : idx;
      if (req[idx[PTRW-1:0]]) begin
        win = idx[PTRW-1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter granting multi-cycle tenures with a turnaround cycle
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 5,
  parameter int MAX_HOLD = 16,
  localparam int PTRW = (clog2(REQUESTERS) > 1) ? clog2(REQUESTERS) : 1,
  localparam int CW = clog2(MAX_HOLD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req,
  input  logic [REQUESTERS-1:0] done,
  output logic [REQUESTERS-1:0] gnt,
  output logic [PTRW-1:0]       owner,
  output logic                  busy,
  output logic                  timeout
);
  state_t state;
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] win;
  logic [CW-1:0] hold_cnt;
  logic found;
  logic rel_done;
  logic rel_drop;
  logic at_max;
  rr_pick #(.N(REQUESTERS), .PTRW(PTRW)) u_pick (
    .req(req),
    .start(ptr),
    .win(win),
    .found(found)
  );
  assign rel_done = done[owner];
  assign rel_drop = !req[owner];
  assign at_max = hold_cnt == CW'(MAX_HOLD);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (found) begin
          gnt <= REQUESTERS'(1) << win;
          owner <= win;
          busy <= 1'b1;
          hold_cnt <= CW'(1);
          ptr <= (win == PTRW'(REQUESTERS - 1)) ? '0 : win + PTRW'(1);
          state <= GRANT;
        end
        GRANT: if (rel_done || rel_drop || at_max) begin
          gnt <= '0;
          busy <= 1'b0;
          // a forced end only counts as timeout when the owner did not release on its own
          timeout <= at_max && !rel_done && !rel_drop;
          state <= TURN;
        end else begin
          hold_cnt <= hold_cnt + CW'(1);
        end
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: table vectors, corner sequences and random traffic against a reference model
module tb_rr_burst_arbiter;
  localparam int N = 5;
  localparam int MH = 4;
  logic clk;
  logic rst;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [2:0] owner;
  logic busy;
  logic timeout;
  int total = 0;
  int bad = 0;
  int m_state, m_owner, m_cnt, m_ptr, m_to;

  typedef struct {
    logic rs;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    int owner;
    logic to;
    int ptr;
  } tv_t;
  tv_t tv[$];

  rr_burst_arbiter #(.REQUESTERS(N), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tv_t mk(logic rs, logic [N-1:0] r, logic [N-1:0] d, logic [N-1:0] g, int o, logic t, int p);
    tv_t v;
    v.rs = rs; v.req = r; v.done = d; v.gnt = g; v.owner = o; v.to = t; v.ptr = p;
    return v;
  endfunction

  function automatic logic [N-1:0] mgnt();
    return (m_state == 1) ? N'(1) << m_owner : '0;
  endfunction

  function automatic int idx_of(logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: idle scans modulo N from ptr, grant ends on done, dropped req or hold limit
  task automatic model_edge();
    int win;
    m_to = 0;
    if (rst) begin
      m_state = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_state == 0) begin
      win = -1;
      for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
        m_state = 1; m_owner = win; m_cnt = 1; m_ptr = (win + 1) % N;
      end
    end else if (m_state == 1) begin
      if (done[m_owner] || !req[m_owner] || m_cnt == MH) begin
        m_to = (m_cnt == MH && !done[m_owner] && req[m_owner]) ? 1 : 0;
        m_state = 2;
      end else m_cnt++;
    end else m_state = 0;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("m_gnt", int'(gnt), int'(mgnt()));
    check("m_owner", int'(owner), m_owner);
    check("m_busy", int'(busy), int'(m_state == 1));
    check("m_timeout", int'(timeout), m_to);
    check("m_ptr", int'(dut.ptr), m_ptr);
  endtask

  initial begin
    int n, last, hi, to_cnt;
    int rot[6] = '{0, 1, 2, 3, 4, 0};
    logic [N-1:0] rr, dd;
    req = '0; done = '0; rst = 1'b1;
    m_state = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_to = 0;
    tv.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0));
    tv.push_back(mk(1, 5'b00100, 5'b00000, 5'b00000, 0, 0, 0));
    tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 2, 0, 3));
    tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 2, 0, 3));
    tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 2, 0, 3));
    tv.push_back(mk(0, 5'b00100, 5'b00100, 5'b00000, 2, 0, 3));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2, 0, 3));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2, 0, 3));
    tv.push_back(mk(0, 5'b01000, 5'b00000, 5'b01000, 3, 0, 4));
    tv.push_back(mk(0, 5'b01001, 5'b00001, 5'b01000, 3, 0, 4));
    tv.push_back(mk(0, 5'b01001, 5'b00001, 5'b01000, 3, 0, 4));
    tv.push_back(mk(0, 5'b01001, 5'b01000, 5'b00000, 3, 0, 4));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 5'b00000, 3, 0, 4));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 5'b10000, 4, 0, 0));
    tv.push_back(mk(1, 5'b10001, 5'b00000, 5'b00000, 0, 0, 0));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 5'b00001, 0, 0, 1));
    tv.push_back(mk(0, 5'b10001, 5'b00001, 5'b00000, 0, 0, 1));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 5'b00000, 0, 0, 1));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 5'b10000, 4, 0, 0));
    tv.push_back(mk(0, 5'b10001, 5'b10000, 5'b00000, 4, 0, 0));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 4, 0, 0));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 4, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 2, 0, 3));
    tv.push_back(mk(0, 5'b00100, 5'b00100, 5'b00000, 2, 0, 3));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2, 0, 3));
    tv.push_back(mk(0, 5'b00010, 5'b00000, 5'b00010, 1, 0, 2));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 2));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 2));
    foreach (tv[i]) begin
      step(tv[i].req, tv[i].done, tv[i].rs);
      check($sformatf("tv%0d_gnt", i), int'(gnt), int'(tv[i].gnt));
      check($sformatf("tv%0d_owner", i), int'(owner), tv[i].owner);
      check($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].gnt != '0));
      check($sformatf("tv%0d_timeout", i), int'(timeout), int'(tv[i].to));
      check($sformatf("tv%0d_ptr", i), int'(dut.ptr), tv[i].ptr);
    end
    // rotation: every owner releases on its first granted cycle
    step('0, '0, 1'b1);
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      step(5'b11111, mgnt(), 1'b0);
      if (gnt != '0) begin
        check("rot_owner", idx_of(gnt), rot[n]);
        if (n > 0) check("rot_gap", cyc - last, 3);
        last = cyc;
        n++;
      end
    end
    check("rot_count", n, 6);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    check("rot_ptr", int'(dut.ptr), 1);
    // timeout: client 1 never releases
    hi = 0;
    to_cnt = 0;
    for (int i = 0; i < 10 && to_cnt == 0; i++) begin
      step(5'b00010, '0, 1'b0);
      hi += int'(gnt[1]);
      to_cnt += int'(timeout);
    end
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b0);
      to_cnt += int'(timeout);
    end
    check("to_hold", hi, MH);
    check("to_pulses", to_cnt, 1);
    check("to_ptr", int'(dut.ptr), 2);
    // random traffic against the model
    rr = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rr ^= N'(1) << $urandom_range(0, N - 1);
      dd = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      step(rr, dd, $urandom_range(0, 299) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
